// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns: one column of the 128-bit state is
// rewritten per clock, with a valid/ready handshake on both the input and output sides.

// Combinational GF(2^8) multiply, reduction polynomial x^8+x^4+x^3+x+1 (0x11B).
module gfmult (
    input  logic [7:0] val_a,
    input  logic [7:0] val_b,
    output logic [7:0] val_p
);
    logic [7:0] w_a [0:7];
    logic [7:0] w_p [0:8];

    assign w_a[0] = val_a;
    assign w_p[0] = 8'h00;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_step
            assign w_p[gi+1] = w_p[gi] ^ (val_b[gi] ? w_a[gi] : 8'h00);
            if (gi < 7) begin : g_xtime
                assign w_a[gi+1] = {w_a[gi][6:0], 1'b0} ^ (w_a[gi][7] ? 8'h1b : 8'h00);
            end
        end
    endgenerate

    assign val_p = w_p[8];
endmodule

module mix_columns_seq #(
    parameter int NUM_COLS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    localparam int COL_W = $clog2(NUM_COLS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [127:0]       r_work;
    logic               r_inv;
    logic [COL_W-1:0]   r_col;
    logic [127:0]       r_out_state;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_in_ready;

    logic [31:0]  w_cols [0:NUM_COLS-1];
    logic [31:0]  w_sel;
    logic [7:0]   w_a    [0:3];
    logic [7:0]   w_m2   [0:3];
    logic [7:0]   w_m3   [0:3];
    logic [7:0]   w_m9   [0:3];
    logic [7:0]   w_mb   [0:3];
    logic [7:0]   w_md   [0:3];
    logic [7:0]   w_me   [0:3];
    logic [7:0]   w_b    [0:3];
    logic [31:0]  w_new_col;
    logic [127:0] w_work_next;
    logic         w_last_col;

    generate
        for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_cols
            assign w_cols[gi] = r_work[127-32*gi -: 32];
            assign w_work_next[127-32*gi -: 32] =
                (r_col == COL_W'(gi)) ? w_new_col : w_cols[gi];
        end
    endgenerate

    assign w_sel      = w_cols[r_col];
    assign w_last_col = (r_col == COL_W'(NUM_COLS - 1));

    // Every constant product of every byte of the active column, both directions.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
            assign w_a[gi] = w_sel[31-8*gi -: 8];

            gfmult u_m2 (.val_a(w_a[gi]), .val_b(8'h02), .val_p(w_m2[gi]));
            gfmult u_m3 (.val_a(w_a[gi]), .val_b(8'h03), .val_p(w_m3[gi]));
            gfmult u_m9 (.val_a(w_a[gi]), .val_b(8'h09), .val_p(w_m9[gi]));
            gfmult u_mb (.val_a(w_a[gi]), .val_b(8'h0b), .val_p(w_mb[gi]));
            gfmult u_md (.val_a(w_a[gi]), .val_b(8'h0d), .val_p(w_md[gi]));
            gfmult u_me (.val_a(w_a[gi]), .val_b(8'h0e), .val_p(w_me[gi]));
        end
    endgenerate

    // Row r uses the coefficient row rotated right by r, i.e. byte (r+k)%4 gets coeff k.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rows
            logic [7:0] w_fwd;
            logic [7:0] w_rev;
            assign w_fwd = w_m2[gi] ^ w_m3[(gi+1)%4] ^ w_a[(gi+2)%4] ^ w_a[(gi+3)%4];
            assign w_rev = w_me[gi] ^ w_mb[(gi+1)%4] ^ w_md[(gi+2)%4] ^ w_m9[(gi+3)%4];
            assign w_b[gi] = r_inv ? w_rev : w_fwd;
        end
    endgenerate

    assign w_new_col = {w_b[0], w_b[1], w_b[2], w_b[3]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_work      <= '0;
            r_inv       <= 1'b0;
            r_col       <= '0;
            r_out_state <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_work     <= in_state;
                        r_inv      <= in_inv;
                        r_col      <= '0;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_work <= w_work_next;
                    r_col  <= r_col + COL_W'(1);
                    if (w_last_col) begin
                        r_out_state <= w_work_next;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_state = r_out_state;
    assign busy      = r_busy;
endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq: known AES column vectors, latency,
// backpressure, mode latching and asynchronous reset abort.
module tb_mix_columns_seq;
    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] S1 = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    localparam logic [127:0] R1 = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam logic [127:0] F0 = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] F1 = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] C6 = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;

    mix_columns_seq #(.NUM_COLS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one state with out_ready=1 and check exact 4-cycle latency and handshake.
    task automatic run_op(input string tag, input logic [127:0] st, input logic inv,
                          input logic toggle, input logic [127:0] exp);
        in_state = st;
        in_inv   = inv;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_state = ~st;
        $display("accept %s state=%h inv=%0b", tag, st, inv);
        chk({tag, "_busy"}, {127'd0, busy}, 128'd1);
        chk({tag, "_in_ready_busy"}, {127'd0, in_ready}, 128'd0);
        for (int k = 1; k <= 3; k++) begin
            if (toggle) in_inv = ~in_inv;
            step();
            chk({tag, "_early_valid"}, {127'd0, out_valid}, 128'd0);
        end
        if (toggle) in_inv = ~in_inv;
        step();
        chk({tag, "_valid"}, {127'd0, out_valid}, 128'd1);
        chk({tag, "_result"}, out_state, exp);
        $display("result %s out_state=%h", tag, out_state);
        step();
        chk({tag, "_valid_drop"}, {127'd0, out_valid}, 128'd0);
        chk({tag, "_in_ready_back"}, {127'd0, in_ready}, 128'd1);
        chk({tag, "_result_held"}, out_state, exp);
        in_inv = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        in_inv    = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_out_state", out_state, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
        @(negedge clk);
        rst = 1'b0;
        step();

        run_op("fwd_s1", S1, 1'b0, 1'b0, R1);
        run_op("inv_s1", R1, 1'b1, 1'b0, S1);
        run_op("fwd_fips", F0, 1'b0, 1'b0, F1);

        // Backpressure: result must hold for 10 cycles and ignore new input pulses.
        out_ready = 1'b0;
        in_state  = S1;
        in_inv    = 1'b0;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("bp_valid", {127'd0, out_valid}, 128'd1);
        chk("bp_result", out_state, R1);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_state = F0;
            step();
            chk("bp_hold_valid", {127'd0, out_valid}, 128'd1);
            chk("bp_hold_state", out_state, R1);
            chk("bp_hold_in_ready", {127'd0, in_ready}, 128'd0);
        end
        $display("backpressure held 10 cycles out_state=%h", out_state);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_release_valid", {127'd0, out_valid}, 128'd0);
        chk("bp_release_in_ready", {127'd0, in_ready}, 128'd1);
        step();
        chk("bp_idle_busy", {127'd0, busy}, 128'd0);
        chk("bp_idle_valid", {127'd0, out_valid}, 128'd0);
        chk("bp_idle_state", out_state, R1);

        // Mode is latched at accept; toggling in_inv during processing has no effect.
        run_op("mode_latch", S1, 1'b0, 1'b1, R1);

        // Asynchronous reset two cycles into an operation.
        in_state = F0;
        in_inv   = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("arst_out_state", out_state, 128'd0);
        chk("arst_busy", {127'd0, busy}, 128'd0);
        chk("arst_in_ready", {127'd0, in_ready}, 128'd1);
        $display("async reset mid-operation out_state=%h", out_state);
        @(negedge clk);
        rst = 1'b0;
        step();
        run_op("post_rst_c6", C6, 1'b0, 1'b0, C6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
